// File: rtl/imem_loader.sv
// Byte-stream loader: packs 4 bytes MSB-first into words and writes them to imem from address 0.
// Latency: mem_we pulses the cycle after the 4th byte handshake; peak rate 1 word per 5 cycles.
// Backpressure: byte_ready is high only while collecting; the source holds its byte otherwise.
module imem_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH + 1)'(MAX_WORDS);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] word_idx_q;
    logic [1:0]            byte_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  done_q;
    logic                  error_q;

    logic start_ok;
    logic bad_count;
    logic xfer;
    logic last_byte;
    logic last_word;

    assign start_ok  = start && (state_q == IDLE || state_q == DONE);
    assign bad_count = (word_count == '0) || ({1'b0, word_count} > MAX_CNT);
    assign xfer      = byte_valid && byte_ready;
    assign last_byte = xfer && (byte_cnt_q == 2'd3);
    assign last_word = (word_idx_q == count_q - ADDR_WIDTH'(1));
    assign done      = done_q;
    assign error     = error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = bad_count ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (last_byte) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we  = 1'b1;
                busy    = 1'b1;
                state_d = last_word ? DONE : COLLECT;
            end
            default: state_d = IDLE;
        endcase
    end

    // The write port registers load on the 4th byte so they are valid during WRITE and hold afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else if (start_ok) begin
            count_q    <= word_count;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            done_q     <= bad_count;
            error_q    <= bad_count;
        end else if (xfer) begin
            shift_q    <= {shift_q[DATA_WIDTH-9:0], byte_in};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                mem_addr  <= word_idx_q;
                mem_wdata <= {shift_q[DATA_WIDTH-9:0], byte_in};
            end
        end else if (state_q == WRITE) begin
            word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
            if (last_word) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-count model predicts every output each cycle,
// and literal expectations pin the written words of each scenario.
module tb_imem_loader;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXW = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] word_count = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic          error;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a load is a count of accepted bytes; every 4th byte yields one write the next cycle.
    bit            m_loading = 0;
    bit            m_wr = 0;
    bit            m_done = 0;
    bit            m_err = 0;
    int            m_bytes = 0;
    int            m_total = 0;
    logic [31:0]   m_cur = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];

    always @(negedge clk) begin
        if (reset) begin
            m_loading = 0; m_wr = 0; m_done = 0; m_err = 0;
            m_bytes = 0; m_total = 0; m_addr = '0; m_data = '0;
            chk("rst_byte_ready", 64'(byte_ready), 64'(0));
            chk("rst_mem_we", 64'(mem_we), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_error", 64'(error), 64'(0));
            chk("rst_mem_addr", 64'(mem_addr), 64'(0));
            chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        end else begin
            bit exp_ready;
            exp_ready = m_loading && !m_wr;
            chk("mdl_byte_ready", 64'(byte_ready), 64'(exp_ready));
            chk("mdl_mem_we", 64'(mem_we), 64'(m_wr));
            chk("mdl_busy", 64'(busy), 64'(m_loading));
            chk("mdl_done", 64'(done), 64'(m_done));
            chk("mdl_error", 64'(error), 64'(m_err));
            chk("mdl_mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mdl_mem_wdata", 64'(mem_wdata), 64'(m_data));
            if (mem_we) begin
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
            end
            if (m_wr) begin
                m_wr = 0;
                if (m_bytes == m_total) begin
                    m_loading = 0;
                    m_done = 1;
                end
            end else if (m_loading) begin
                if (byte_valid && exp_ready) begin
                    m_cur = {m_cur[23:0], byte_in};
                    m_bytes++;
                    if (m_bytes % 4 == 0) begin
                        m_wr = 1;
                        m_addr = AW'(m_bytes / 4 - 1);
                        m_data = m_cur;
                    end
                end
            end else if (start) begin
                if (word_count == 0 || int'(word_count) > MAXW) begin
                    m_done = 1; m_err = 1;
                end else begin
                    m_done = 0; m_err = 0;
                    m_loading = 1; m_bytes = 0; m_total = 4 * int'(word_count);
                end
            end
        end
    end

    task automatic do_start(input int n);
        start = 1'b1;
        word_count = AW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        byte_in = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = byte_ready;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        if (!got) chk("byte_handshake_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
        end
        chk("wait_done", 64'(done), 64'(1));
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    logic [7:0] t2_bytes[8] = '{8'h20, 8'h00, 8'h00, 8'h04, 8'h11, 8'h11, 8'h11, 8'h11};
    logic [7:0] t3_bytes[7] = '{8'hDE, 8'h55, 8'h55, 8'hAD, 8'h55, 8'hBE, 8'hEF};
    bit         t3_vld[7]   = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset mid-cycle, with a load in flight, clears outputs without a clock edge.
        do_start(2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        chk("t1_busy_before_reset", 64'(busy), 64'(1));
        #3 reset = 1'b1;
        #1;
        chk("t1_busy", 64'(busy), 64'(0));
        chk("t1_byte_ready", 64'(byte_ready), 64'(0));
        chk("t1_done", 64'(done), 64'(0));
        @(posedge clk); #1 reset = 1'b0;

        // Two words back-to-back.
        clear_log();
        do_start(2);
        foreach (t2_bytes[i]) send_byte(t2_bytes[i]);
        wait_done(10);
        chk("t2_busy", 64'(busy), 64'(0));
        chk("t2_error", 64'(error), 64'(0));
        chk("t2_nwrites", 64'(log_addr.size()), 64'(2));
        if (log_addr.size() == 2) begin
            chk("t2_addr0", 64'(log_addr[0]), 64'(0));
            chk("t2_data0", 64'(log_data[0]), 64'(32'h2000_0004));
            chk("t2_addr1", 64'(log_addr[1]), 64'(1));
            chk("t2_data1", 64'(log_data[1]), 64'(32'h1111_1111));
        end

        // One word with gaps in byte_valid, started from DONE.
        clear_log();
        do_start(1);
        for (int i = 0; i < 7; i++) begin
            byte_valid = t3_vld[i];
            byte_in = t3_bytes[i];
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        wait_done(10);
        chk("t3_nwrites", 64'(log_addr.size()), 64'(1));
        if (log_addr.size() == 1) begin
            chk("t3_addr0", 64'(log_addr[0]), 64'(0));
            chk("t3_data0", 64'(log_data[0]), 64'(32'hDEAD_BEEF));
        end

        // Invalid counts: zero and one past the depth; offered bytes must not be taken.
        clear_log();
        do_start(0);
        chk("t4a_done", 64'(done), 64'(1));
        chk("t4a_error", 64'(error), 64'(1));
        byte_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 byte_valid = 1'b0;
        do_start(MAXW + 1);
        chk("t4b_done", 64'(done), 64'(1));
        chk("t4b_error", 64'(error), 64'(1));
        chk("t4b_byte_ready", 64'(byte_ready), 64'(0));
        chk("t4_nwrites", 64'(log_addr.size()), 64'(0));

        // Start while busy is ignored; reset abandons the load; a fresh load then works.
        clear_log();
        do_start(3);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
        do_start(1);
        chk("t5_busy_after_2nd_start", 64'(busy), 64'(1));
        send_byte(8'h06);
        reset = 1'b1;
        #1;
        chk("t5_busy_in_reset", 64'(busy), 64'(0));
        @(posedge clk); #1 reset = 1'b0;
        chk("t5_nwrites", 64'(log_addr.size()), 64'(1));
        if (log_addr.size() == 1) begin
            chk("t5_addr0", 64'(log_addr[0]), 64'(0));
            chk("t5_data0", 64'(log_data[0]), 64'(32'h0102_0304));
        end
        clear_log();
        do_start(1);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h01);
        wait_done(10);
        chk("t5_fresh_nwrites", 64'(log_addr.size()), 64'(1));
        if (log_addr.size() == 1) begin
            chk("t5_fresh_addr", 64'(log_addr[0]), 64'(0));
            chk("t5_fresh_data", 64'(log_data[0]), 64'(32'hCAFE_0001));
        end

        // Full-depth load with an incrementing byte pattern.
        clear_log();
        do_start(MAXW);
        for (int i = 0; i < 4 * MAXW; i++) send_byte(i[7:0]);
        wait_done(10);
        chk("t6_error", 64'(error), 64'(0));
        chk("t6_nwrites", 64'(log_addr.size()), 64'(MAXW));
        if (log_addr.size() == MAXW) begin
            chk("t6_data1", 64'(log_data[1]), 64'(32'h0405_0607));
            chk("t6_last_addr", 64'(log_addr[MAXW-1]), 64'(MAXW - 1));
            chk("t6_last_data", 64'(log_data[MAXW-1]), 64'(32'hFCFD_FEFF));
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequential writer for the word-addressed instruction memory of the multi-cycle processor.
- Accepts a byte stream over a valid/ready handshake and packs 4 bytes, MSB first, into each 32-bit word.
- Writes each word to the memory write port at consecutive word addresses starting from 0, then flags completion.
- Used to preload programs before the core is released from reset; the memory's combinational read port is untouched.

Parameters:
ADDR_WIDTH, 16, width of the memory word address (matches the instruction address width)
DATA_WIDTH, 32, memory word width; fixed at 4 bytes, other values unsupported
MAX_WORDS, 256, memory depth in words; upper bound on the load length

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load, honoured only in IDLE or DONE
word_count  input  ADDR_WIDTH  number of words to load; sampled on the accepted start
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  memory write enable, one-cycle pulse per word
mem_addr  output  ADDR_WIDTH  memory word address
mem_wdata  output  DATA_WIDTH  memory write data
busy  output  1  load in progress (COLLECT or WRITE)
done  output  1  load finished; held until the next accepted start
error  output  1  invalid word_count; held until the next accepted start

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - byte_ready, mem_we, busy, done and error are 0.
  - mem_addr, mem_wdata, the byte counter and the word counter are 0.
  - Asserting reset mid-load abandons the load. Words already written stay in memory.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE / DONE, on start:
  - Latch word_count. Clear done and error. Clear the byte and word counters.
  - If word_count == 0 or word_count > MAX_WORDS: go to DONE with done=1 and error=1, and no memory write.
  - Otherwise go to COLLECT.
- COLLECT:
  - byte_ready=1.
  - A byte transfer occurs on any cycle with byte_valid && byte_ready.
  - Byte k of the word (k = 0..3) is stored in bits [31-8k -: 8]; the first byte is the MSB.
  - byte_valid low: hold; no counter change.
  - On the transfer of the 4th byte, go to WRITE.
- WRITE (exactly 1 cycle):
  - byte_ready=0 and mem_we=1.
  - mem_addr = word index (0-based). mem_wdata = the packed word.
  - Next cycle: increment the word index.
    - If the index just written == latched count − 1, go to DONE with done=1.
    - Otherwise return to COLLECT.
- Timing:
  - The mem_we pulse occurs in the cycle immediately after the 4th byte handshake.
  - Peak throughput is 1 word per 5 cycles.
- mem_we is 0 in every state except WRITE.
- mem_addr and mem_wdata hold their last values outside WRITE.
- start while busy=1 is ignored and has no effect on counters.
- start in the same cycle as the final WRITE is ignored. The loader enters DONE, and a new start is accepted from DONE.
- byte_valid in IDLE, DONE or WRITE is not accepted (byte_ready=0); the upstream source holds the byte.
- Word-index arithmetic is ADDR_WIDTH bits. The index never reaches MAX_WORDS because of the count check at start.
- The last loaded word lands at address count−1; no address wrap-around is possible.

Test Plan:
1. Reset asserted mid-cycle with no clock edge -> all outputs 0 immediately, state IDLE.
2. start with word_count=2, then bytes 20,00,00,04,11,11,11,11 sent back-to-back with byte_valid=1 ->
   - mem_we pulses twice: addr 0 with data 32'h2000_0004, then addr 1 with data 32'h1111_1111.
   - done=1 from the cycle after the second WRITE; busy=0.
3. start with word_count=1; byte_valid toggles 1,0,0,1,0,1,1 carrying DE,AD,BE,EF ->
   - Exactly one write: addr 0, data 32'hDEAD_BEEF.
   - byte_ready stays high through the valid gaps; no extra bytes are consumed.
4. start with word_count=0, and separately with word_count=MAX_WORDS+1 ->
   - done=1 and error=1 on the next cycle.
   - mem_we never asserts; byte_ready stays 0.
5. start with word_count=3; second start pulse issued after 5 bytes; reset asserted after 6 bytes ->
   - The second start is ignored.
   - Exactly one write occurs (addr 0).
   - After reset: IDLE, all outputs 0. A fresh start with word_count=1 completes normally at addr 0.
6. Load of MAX_WORDS words with incrementing pattern data ->
   - The last write is at addr MAX_WORDS−1 with correct data.
   - done asserts; error=0.
